mem_stream_loader: RTL
======================

Name: mem_stream_loader

Overview:
Write-side counterpart to the single-port ROM/RAM read path. It accepts a valid/ready data stream and writes it into a memory write port at consecutive addresses from a programmable base. It can then read the same region back through the memory read port and compare additive checksums. Used for runtime loading and self-checking of on-chip memories in place of a static init file.

Parameters:
DATA_WIDTH, 16, width of each memory word and of the stream data.
ADDR_WIDTH, 8, memory address width; depth is 2**ADDR_WIDTH.
OUTPUT_REG, "FALSE", memory read latency: "FALSE" means 1 cycle, "TRUE" means 2 cycles.
VERIFY, "TRUE", if "TRUE" a read-back checksum pass follows the load; if "FALSE" the block goes straight to DONE.

Ports:
clk  in  1  single clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a load when idle.
base_addr  in  ADDR_WIDTH  first write address; sampled on accepted start.
length  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; sampled on accepted start.
s_valid  in  1  stream word available.
s_data  in  DATA_WIDTH  stream word.
s_ready  out  1  block accepts a word when s_valid&&s_ready.
wr_en  out  1  memory write enable.
wr_addr  out  ADDR_WIDTH  memory write address.
wr_data  out  DATA_WIDTH  memory write data.
rd_addr  out  ADDR_WIDTH  memory read address.
rd_data  in  DATA_WIDTH  memory read data, valid READ_LAT cycles after rd_addr.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse at completion.
pass  out  1  checksum result; valid from done until the next accepted start.
checksum  out  DATA_WIDTH  write-side checksum of the last load.

Behaviour:
- Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, done=0, pass=0, checksum=0. FSM goes to IDLE and the read-valid pipe clears.
- Reset asserted mid-operation aborts immediately and asynchronously. Outputs take their reset values, with no partial-write glitch on wr_en.
- READ_LAT = 1 when OUTPUT_REG="FALSE", otherwise 2.
- IDLE: s_ready=0. On start: latch base_addr and length, clear wsum and rsum, set busy=1. If length==0, go to DONE; else go to WRITE. start is ignored while busy.
- WRITE: s_ready=1. Each handshake registers wr_en=1, wr_addr=ptr, wr_data=s_data on the next edge.
  - ptr increments modulo 2**ADDR_WIDTH, so the address wraps from 2**ADDR_WIDTH-1 to 0.
  - wsum = wsum + s_data, modulo 2**DATA_WIDTH.
  - With no handshake, wr_en=0.
  - When the last word is accepted, s_ready drops in the same cycle (combinational on count). Go to VERIFY if VERIFY="TRUE", else DONE.
  - Throughput is 1 word/cycle.
- VERIFY: issue rd_addr=base+i for i=0..length-1, one per cycle, wrapping identically.
  - The first read issues on the cycle after the final write edge, so read-after-write to the same address is safe.
  - A READ_LAT-deep valid shift register tags the returning rd_data; each tagged word adds to rsum.
  - After the last issue, go to FLUSH.
- FLUSH: wait until the valid pipe is empty, then go to DONE.
- DONE: one cycle. done=1, busy=0, checksum=wsum, pass=(wsum==rsum) (pass=1 when VERIFY="FALSE" or length==0). Return to IDLE.
- length=2**ADDR_WIDTH: the entire memory is written once and the final ptr equals base_addr.
- s_valid high outside WRITE: no handshake and no effect.

Decomposition:
- Shared package mem_loader_pkg:
  - FSM state encoding: IDLE, WRITE, VERIFY, FLUSH, DONE.
  - Function read_lat(OUTPUT_REG) returning 1 or 2.
- One natural sub-module, mem_read_tracker: the READ_LAT valid shift register, rsum accumulator and pipe-empty flag.

Test Plan:
1. Each case instantiates the existing single-port RAM, with the memory read port driven by rd_addr and the write port driven by wr_*.
2. base=0x00, length=256, s_data=0xFF-i, s_valid always high, OUTPUT_REG="FALSE" -> 256 consecutive wr_en cycles; mem[i]==0xFF-i; done once; pass=1; checksum=0x7F80.
3. base=0xF0, length=32, s_data=i, random s_valid gaps -> writes to 0xF0..0xFF then 0x00..0x0F; no write on gap cycles; checksum=0x01F0; pass=1.
4. OUTPUT_REG="TRUE", length=4, data 0x1111,0x2222,0x3333,0x4444, with the bench forcing mem[1]=0 before VERIFY -> pass=0, checksum=0xAAAA.
5. length=0 start -> busy for exactly 1 cycle, done pulse on the next cycle, no wr_en, pass=1.
6. reset asserted after 10 of 100 words -> wr_en, busy and s_ready go to 0 immediately. A second start during busy on a fresh run is ignored (length unchanged, single done).

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the stream-to-memory loader.
//   loader_state_e : loader FSM states
//   read_lat()     : memory read latency in cycles (1 without an output register, 2 with)
package mem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StVerify,
    StFlush,
    StDone
  } loader_state_e;

  function automatic int unsigned read_lat(input bit output_reg_true);
    return output_reg_true ? 32'd2 : 32'd1;
  endfunction

endpackage

// File: rtl/mem_read_tracker.sv
// Read-back tracker for the loader's verify pass.
// Tags each issued read through a READ_LAT-deep valid pipe. Each tagged rd_data word is
// added into a running checksum.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_clear        : clears the checksum (new load accepted)
//   i_issue        : a read address is presented this cycle
//   i_rd_data      : memory read data, valid READ_LAT cycles after its issue
//   o_rsum         : additive read-side checksum, modulo 2**DATA_WIDTH
//   o_empty        : no reads in flight
module mem_read_tracker
  import mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_issue,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_rsum,
  output logic                  o_empty
);

  logic [READ_LAT-1:0]   r_vld;
  logic [READ_LAT-1:0]   w_vld_d;
  logic [DATA_WIDTH-1:0] r_rsum;

  // Shift towards the MSB. The MSB marks the cycle in which rd_data belongs to an issue.
  always_comb begin
    w_vld_d    = r_vld << 1;
    w_vld_d[0] = i_issue;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vld  <= '0;
      r_rsum <= '0;
    end else begin
      r_vld <= w_vld_d;
      if (i_clear) begin
        r_rsum <= '0;
      end else if (r_vld[READ_LAT-1]) begin
        r_rsum <= r_rsum + i_rd_data;
      end
    end
  end

  always_comb begin
    o_rsum  = r_rsum;
    o_empty = (r_vld == '0);
  end

endmodule

// File: rtl/mem_stream_loader.sv
// Loads a valid/ready word stream into a memory write port. Words go to consecutive
// addresses from a programmable base, and the address wraps at the top of memory. After
// the load, the block can read the same region back and compare additive checksums.
//   i_clk, i_reset           : clock, asynchronous active-high reset
//   i_start                  : one-cycle pulse, accepted only when idle
//   i_base_addr, i_length    : first address and word count (0..2**ADDR_WIDTH), sampled on start
//   i_s_valid/i_s_data       : input stream; o_s_ready completes the handshake
//   o_wr_en/addr/data        : memory write port (registered)
//   o_rd_addr, i_rd_data     : memory read port, READ_LAT cycles of latency
//   o_busy, o_done           : activity flag and one-cycle completion pulse
//   o_pass, o_checksum       : verify result and write-side checksum, held until next start
module mem_stream_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter string       OUTPUT_REG = "FALSE",
  parameter string       VERIFY     = "TRUE"
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  input  logic                  i_s_valid,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [DATA_WIDTH-1:0] o_checksum
);

  localparam int unsigned ReadLat  = read_lat(OUTPUT_REG == "TRUE");
  localparam bit          DoVerify = (VERIFY == "TRUE");
  localparam int unsigned CntW     = ADDR_WIDTH + 1;

  loader_state_e r_state, w_state_d;

  logic [CntW-1:0]       r_len;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [CntW-1:0]       r_wr_cnt;
  logic [DATA_WIDTH-1:0] r_wsum;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [CntW-1:0]       r_rd_cnt;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic                  r_pass;

  logic                  w_start_acc;
  logic                  w_ready;
  logic                  w_hs;
  logic                  w_last_wr;
  logic                  w_issue;
  logic                  w_last_rd;
  logic                  w_rd_empty;
  logic                  w_pass_now;
  logic [DATA_WIDTH-1:0] w_rsum;

  always_comb begin
    w_start_acc = (r_state == StIdle) && i_start;
    // Ready drops as soon as the count is reached, independent of the state change.
    w_ready     = (r_state == StWrite) && (r_wr_cnt != r_len);
    w_hs        = w_ready && i_s_valid;
    w_last_wr   = w_hs && (r_wr_cnt == r_len - CntW'(1));
    // The first verify cycle still carries the final write pulse. Holding off the first
    // read until that write has landed keeps read-after-write to one address safe.
    w_issue     = (r_state == StVerify) && !r_wr_en;
    w_last_rd   = w_issue && (r_rd_cnt == r_len - CntW'(1));
    w_pass_now  = !DoVerify || (r_wsum == w_rsum);
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_d = (i_length == '0) ? StDone : StWrite;
      end
      StWrite: begin
        if (w_last_wr) w_state_d = DoVerify ? StVerify : StDone;
      end
      StVerify: begin
        if (w_last_rd) w_state_d = StFlush;
      end
      StFlush: begin
        if (w_rd_empty) w_state_d = StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_wr_ptr   <= '0;
      r_wr_cnt   <= '0;
      r_wsum     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_checksum <= '0;
      r_pass     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wr_en <= w_hs;

      if (w_start_acc) begin
        r_len     <= i_length;
        r_wr_ptr  <= i_base_addr;
        r_wr_cnt  <= '0;
        r_wsum    <= '0;
        r_rd_addr <= i_base_addr;
        r_rd_cnt  <= '0;
      end

      if (w_hs) begin
        r_wr_addr <= r_wr_ptr;
        r_wr_data <= i_s_data;
        r_wr_ptr  <= r_wr_ptr + ADDR_WIDTH'(1);
        r_wr_cnt  <= r_wr_cnt + CntW'(1);
        r_wsum    <= r_wsum + i_s_data;
      end

      if (w_issue) begin
        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
        r_rd_cnt  <= r_rd_cnt + CntW'(1);
      end

      // Capture the result so it stays visible after the done pulse.
      if (r_state == StDone) begin
        r_checksum <= r_wsum;
        r_pass     <= w_pass_now;
      end
    end
  end

  mem_read_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .READ_LAT  (ReadLat)
  ) u_read_tracker (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_start_acc),
    .i_issue  (w_issue),
    .i_rd_data(i_rd_data),
    .o_rsum   (w_rsum),
    .o_empty  (w_rd_empty)
  );

  always_comb begin
    o_s_ready  = w_ready;
    o_wr_en    = r_wr_en;
    o_wr_addr  = r_wr_addr;
    o_wr_data  = r_wr_data;
    o_rd_addr  = r_rd_addr;
    o_busy     = w_start_acc || (r_state inside {StWrite, StVerify, StFlush});
    o_done     = (r_state == StDone);
    // During the done cycle the live result is shown. Afterwards the captured copy is shown.
    o_checksum = (r_state == StDone) ? r_wsum : r_checksum;
    o_pass     = (r_state == StDone) ? w_pass_now : r_pass;
  end

endmodule
